// File: rtl/regfile_pkg.sv
// Shared definitions for the register file with pending scoreboard.
//   XLEN_DEFAULT / NREGS_DEFAULT : default data width and register count
//   reg_data_t / reg_addr_t      : data and address types at the default sizing
//   ZERO_REG                     : index of the hardwired-zero register
package regfile_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned NREGS_DEFAULT = 32;

  typedef logic [XLEN_DEFAULT-1:0]          reg_data_t;
  typedef logic [$clog2(NREGS_DEFAULT)-1:0] reg_addr_t;

  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending scoreboard.
// Ports:
//   clk_i, reset_i          : clock, synchronous active-high reset
//   issue_en_i, issue_addr_i: mark destination register pending
//   wrt_en_i, wrt_addr_i    : write-back clears the pending bit
//   flush_i                 : clear every pending bit (this cycle's issue still applies)
//   pending_o               : current pending vector (bit 0 is always 0)
//   wb_unexp_o              : registered pulse, last write-back hit a non-pending register
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEFAULT,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             issue_en_i,
  input  logic [AW-1:0]    issue_addr_i,
  input  logic             wrt_en_i,
  input  logic [AW-1:0]    wrt_addr_i,
  input  logic             flush_i,
  output logic [NREGS-1:0] pending_o,
  output logic             wb_unexp_o
);

  logic [NREGS-1:0] pending_q, pending_d;
  logic             wb_unexp_q, wb_unexp_d;
  logic             wrt_hit, issue_hit;

  assign wrt_hit   = wrt_en_i & (wrt_addr_i != AW'(ZERO_REG));
  assign issue_hit = issue_en_i & (issue_addr_i != AW'(ZERO_REG));

  // Priority: write-back clear, then flush, then issue set (issue wins).
  always_comb begin
    pending_d = pending_q;
    if (wrt_hit) pending_d[wrt_addr_i] = 1'b0;
    if (flush_i) pending_d = '0;
    if (issue_hit) pending_d[issue_addr_i] = 1'b1;
    pending_d[ZERO_REG] = 1'b0;
    // Sampled against the pre-update pending state.
    wb_unexp_d = wrt_hit & ~pending_q[wrt_addr_i];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pending_q  <= '0;
      wb_unexp_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      wb_unexp_q <= wb_unexp_d;
    end
  end

  assign pending_o  = pending_q;
  assign wb_unexp_o = wb_unexp_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with per-register pending scoreboard.
// Two asynchronous read ports, one clocked write-back port, x0 hardwired to zero.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   rg_rd_addrN / rg_rd_dataN       : read address / data (N = 1, 2)
//   rg_rd_rdyN                      : read register not pending
//   issue_en, issue_addr, issue_ok  : mark destination pending / destination is WAW-free
//   rg_wrt_en/addr/data             : write-back port
//   flush                           : clear all pending bits, data kept
//   wb_unexp                        : pulse, previous write-back hit a non-pending register
// Build option: define REGFILE_BYPASS_EN to forward write-back data/ready to the
// read ports and issue_ok in the same cycle.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned NREGS = NREGS_DEFAULT,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rg_rd_addr1,
  input  logic [AW-1:0]   rg_rd_addr2,
  output logic [XLEN-1:0] rg_rd_data1,
  output logic [XLEN-1:0] rg_rd_data2,
  output logic            rg_rd_rdy1,
  output logic            rg_rd_rdy2,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_addr,
  output logic            issue_ok,
  input  logic            rg_wrt_en,
  input  logic [AW-1:0]   rg_wrt_addr,
  input  logic [XLEN-1:0] rg_wrt_data,
  input  logic            flush,
  output logic            wb_unexp
);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [NREGS-1:0] pending;
  logic             wrt_hit;

  assign wrt_hit = rg_wrt_en & (rg_wrt_addr != AW'(ZERO_REG));

  // Entry 0 is never written, so it holds its reset value of zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) mem_q[i] <= '0;
    end else if (wrt_hit) begin
      mem_q[rg_wrt_addr] <= rg_wrt_data;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk_i        (clk),
    .reset_i      (reset),
    .issue_en_i   (issue_en),
    .issue_addr_i (issue_addr),
    .wrt_en_i     (rg_wrt_en),
    .wrt_addr_i   (rg_wrt_addr),
    .flush_i      (flush),
    .pending_o    (pending),
    .wb_unexp_o   (wb_unexp)
  );

`ifdef REGFILE_BYPASS_EN
  logic byp_ok;
  assign byp_ok = wrt_hit & ~reset;

  always_comb begin
    rg_rd_data1 = mem_q[rg_rd_addr1];
    rg_rd_rdy1  = ~pending[rg_rd_addr1];
    rg_rd_data2 = mem_q[rg_rd_addr2];
    rg_rd_rdy2  = ~pending[rg_rd_addr2];
    issue_ok    = ~pending[issue_addr];
    if (byp_ok && (rg_wrt_addr == rg_rd_addr1)) begin
      rg_rd_data1 = rg_wrt_data;
      rg_rd_rdy1  = 1'b1;
    end
    if (byp_ok && (rg_wrt_addr == rg_rd_addr2)) begin
      rg_rd_data2 = rg_wrt_data;
      rg_rd_rdy2  = 1'b1;
    end
    if (byp_ok && (rg_wrt_addr == issue_addr)) issue_ok = 1'b1;
  end
`else
  assign rg_rd_data1 = mem_q[rg_rd_addr1];
  assign rg_rd_rdy1  = ~pending[rg_rd_addr1];
  assign rg_rd_data2 = mem_q[rg_rd_addr2];
  assign rg_rd_rdy2  = ~pending[rg_rd_addr2];
  assign issue_ok    = ~pending[issue_addr];
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed, table-driven bench for regfile_sb.
module tb_regfile_sb;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rg_rd_addr1, rg_rd_addr2, issue_addr, rg_wrt_addr;
  logic [31:0] rg_rd_data1, rg_rd_data2, rg_wrt_data;
  logic        rg_rd_rdy1, rg_rd_rdy2, issue_en, issue_ok, rg_wrt_en, flush, wb_unexp;

  int checks = 0;
  int errors = 0;

  regfile_sb dut (
    .clk         (clk),
    .reset       (reset),
    .rg_rd_addr1 (rg_rd_addr1),
    .rg_rd_addr2 (rg_rd_addr2),
    .rg_rd_data1 (rg_rd_data1),
    .rg_rd_data2 (rg_rd_data2),
    .rg_rd_rdy1  (rg_rd_rdy1),
    .rg_rd_rdy2  (rg_rd_rdy2),
    .issue_en    (issue_en),
    .issue_addr  (issue_addr),
    .issue_ok    (issue_ok),
    .rg_wrt_en   (rg_wrt_en),
    .rg_wrt_addr (rg_wrt_addr),
    .rg_wrt_data (rg_wrt_data),
    .flush       (flush),
    .wb_unexp    (wb_unexp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iss_en;
    logic [4:0]  iss_a;
    logic        wr_en;
    logic [4:0]  wr_a;
    logic [31:0] wr_d;
    logic        fl;
    logic [4:0]  rd1;
    logic [4:0]  rd2;
    logic [31:0] e_d1;
    logic        e_r1;
    logic [31:0] e_d2;
    logic        e_r2;
    logic        e_ok;
    logic        e_ux;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  function automatic vec_t mkv(int rst, int iss_en, int iss_a, int wr_en, int wr_a,
                               logic [31:0] wr_d, int fl, int rd1, int rd2,
                               logic [31:0] e_d1, int e_r1, logic [31:0] e_d2, int e_r2,
                               int e_ok, int e_ux);
    vec_t v;
    v.rst = 1'(rst);     v.iss_en = 1'(iss_en); v.iss_a = 5'(iss_a);
    v.wr_en = 1'(wr_en); v.wr_a = 5'(wr_a);     v.wr_d = wr_d;
    v.fl = 1'(fl);       v.rd1 = 5'(rd1);       v.rd2 = 5'(rd2);
    v.e_d1 = e_d1;       v.e_r1 = 1'(e_r1);     v.e_d2 = e_d2;
    v.e_r2 = 1'(e_r2);   v.e_ok = 1'(e_ok);     v.e_ux = 1'(e_ux);
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_strobes();
    reset = 1'b0; issue_en = 1'b0; rg_wrt_en = 1'b0; flush = 1'b0;
  endtask

  // Strobes are held across one rising edge, then dropped so the checks see clocked state.
  task automatic cycle();
    @(posedge clk);
    #1;
    clear_strobes();
    #1;
  endtask

  initial begin
    // rst ie ia we wa wd fl rd1 rd2 | d1 r1 d2 r2 ok ux
    vecs[0]  = mkv(1, 0, 0, 0, 0, 32'h0,        0, 0,  0,  32'h0,        1, 32'h0,        1, 1, 0);
    vecs[1]  = mkv(0, 0, 5, 1, 5, 32'hDEADBEEF, 0, 5,  0,  32'hDEADBEEF, 1, 32'h0,        1, 1, 1);
    vecs[2]  = mkv(0, 0, 0, 1, 0, 32'h1234,     0, 0,  5,  32'h0,        1, 32'hDEADBEEF, 1, 1, 0);
    vecs[3]  = mkv(0, 1, 7, 0, 0, 32'h0,        0, 7,  5,  32'h0,        0, 32'hDEADBEEF, 1, 0, 0);
    vecs[4]  = mkv(0, 0, 7, 0, 0, 32'h0,        0, 7,  5,  32'h0,        0, 32'hDEADBEEF, 1, 0, 0);
    vecs[5]  = mkv(0, 0, 7, 0, 0, 32'h0,        0, 7,  5,  32'h0,        0, 32'hDEADBEEF, 1, 0, 0);
    vecs[6]  = mkv(0, 0, 7, 1, 7, 32'h55,       0, 7,  5,  32'h55,       1, 32'hDEADBEEF, 1, 1, 0);
    vecs[7]  = mkv(0, 1, 9, 1, 9, 32'h99,       0, 9,  7,  32'h99,       0, 32'h55,       1, 0, 1);
    vecs[8]  = mkv(0, 0, 9, 0, 0, 32'h0,        1, 9,  7,  32'h99,       1, 32'h55,       1, 1, 0);
    vecs[9]  = mkv(0, 0, 3, 1, 3, 32'h33,       0, 3,  9,  32'h33,       1, 32'h99,       1, 1, 1);
    vecs[10] = mkv(0, 0, 3, 0, 0, 32'h0,        0, 3,  9,  32'h33,       1, 32'h99,       1, 1, 0);
    vecs[11] = mkv(0, 1, 4, 0, 0, 32'h0,        0, 4,  3,  32'h0,        0, 32'h33,       1, 0, 0);
    vecs[12] = mkv(0, 1, 4, 1, 4, 32'h44,       0, 4,  3,  32'h44,       0, 32'h33,       1, 0, 0);
    vecs[13] = mkv(1, 1, 10, 1, 10, 32'hAA,     0, 4,  5,  32'h0,        1, 32'h0,        1, 1, 0);
    vecs[14] = mkv(0, 1, 11, 0, 0, 32'h0,       1, 11, 10, 32'h0,        0, 32'h0,        1, 0, 0);
    vecs[15] = mkv(0, 1, 12, 1, 11, 32'hBB,     1, 11, 12, 32'hBB,       1, 32'h0,        0, 0, 0);
    vecs[16] = mkv(0, 1, 0, 1, 0, 32'hCC,       0, 0,  12, 32'h0,        1, 32'h0,        0, 1, 0);

    clear_strobes();
    rg_rd_addr1 = '0; rg_rd_addr2 = '0; issue_addr = '0; rg_wrt_addr = '0; rg_wrt_data = '0;

    // Reset, then sweep every address.
    reset = 1'b1;
    cycle();
    for (int a = 0; a < 32; a++) begin
      rg_rd_addr1 = 5'(a); rg_rd_addr2 = 5'(31 - a); issue_addr = 5'(a);
      #1;
      chk($sformatf("rst_data1[%0d]", a), rg_rd_data1, 32'h0);
      chk($sformatf("rst_rdy1[%0d]", a), 32'(rg_rd_rdy1), 32'h1);
      chk($sformatf("rst_rdy2[%0d]", 31 - a), 32'(rg_rd_rdy2), 32'h1);
      chk($sformatf("rst_issue_ok[%0d]", a), 32'(issue_ok), 32'h1);
    end
    chk("rst_wb_unexp", 32'(wb_unexp), 32'h0);

    for (int i = 0; i < NV; i++) begin
      reset = vecs[i].rst; issue_en = vecs[i].iss_en; issue_addr = vecs[i].iss_a;
      rg_wrt_en = vecs[i].wr_en; rg_wrt_addr = vecs[i].wr_a; rg_wrt_data = vecs[i].wr_d;
      flush = vecs[i].fl; rg_rd_addr1 = vecs[i].rd1; rg_rd_addr2 = vecs[i].rd2;
      cycle();
      chk($sformatf("v%0d_data1", i), rg_rd_data1, vecs[i].e_d1);
      chk($sformatf("v%0d_rdy1", i), 32'(rg_rd_rdy1), 32'(vecs[i].e_r1));
      chk($sformatf("v%0d_data2", i), rg_rd_data2, vecs[i].e_d2);
      chk($sformatf("v%0d_rdy2", i), 32'(rg_rd_rdy2), 32'(vecs[i].e_r2));
      chk($sformatf("v%0d_issue_ok", i), 32'(issue_ok), 32'(vecs[i].e_ok));
      chk($sformatf("v%0d_wb_unexp", i), 32'(wb_unexp), 32'(vecs[i].e_ux));
    end

    // Same-cycle write/read of a pending x6: forwarded only with the bypass build.
    issue_en = 1'b1; issue_addr = 5'd6; rg_rd_addr1 = 5'd6; rg_rd_addr2 = 5'd0;
    cycle();
    chk("byp_pre_rdy1", 32'(rg_rd_rdy1), 32'h0);
    rg_wrt_en = 1'b1; rg_wrt_addr = 5'd6; rg_wrt_data = 32'hA5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_data1", rg_rd_data1, 32'hA5A5);
    chk("byp_rdy1", 32'(rg_rd_rdy1), 32'h1);
    chk("byp_issue_ok", 32'(issue_ok), 32'h1);
`else
    chk("nobyp_data1", rg_rd_data1, 32'h0);
    chk("nobyp_rdy1", 32'(rg_rd_rdy1), 32'h0);
    chk("nobyp_issue_ok", 32'(issue_ok), 32'h0);
`endif
    chk("byp_rdy2_x0", 32'(rg_rd_rdy2), 32'h1);
    cycle();
    chk("byp_post_data1", rg_rd_data1, 32'hA5A5);
    chk("byp_post_rdy1", 32'(rg_rd_rdy1), 32'h1);
    chk("byp_post_unexp", 32'(wb_unexp), 32'h0);

    // No forwarding while reset is asserted, in either build.
    reset = 1'b1; rg_wrt_en = 1'b1; rg_wrt_addr = 5'd6; rg_wrt_data = 32'h1111;
    #1;
    chk("rstbyp_data1", rg_rd_data1, 32'hA5A5);
    chk("rstbyp_rdy1", 32'(rg_rd_rdy1), 32'h1);
    cycle();
    chk("rstbyp_post_data1", rg_rd_data1, 32'h0);
    chk("rstbyp_post_unexp", 32'(wb_unexp), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with a per-register pending scoreboard, for the pipelined successor of the single-cycle RISC-V core. It has two combinational read ports and one clocked write-back port. Each register has a pending bit that is set when an instruction targeting it issues and cleared when its write-back lands, so decode can detect RAW/WAW hazards without a separate hazard table. Register 0 is hardwired to zero and is never pending.

## Interface
- XLEN, 32, data width of each register
- NREGS, 32, register count; power of two, ≥ 2
- AW, $clog2(NREGS), address width (derived; do not override)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- rg_rd_addr1  in  AW  read port 1 address
- rg_rd_addr2  in  AW  read port 2 address
- rg_rd_data1  out  XLEN  read port 1 data
- rg_rd_data2  out  XLEN  read port 2 data
- rg_rd_rdy1  out  1  read port 1 register not pending
- rg_rd_rdy2  out  1  read port 2 register not pending
- issue_en  in  1  mark issue_addr pending this cycle
- issue_addr  in  AW  destination register of the issuing instruction
- issue_ok  out  1  issue_addr is not pending (WAW-free); combinational
- rg_wrt_en  in  1  write-back strobe
- rg_wrt_addr  in  AW  write-back address
- rg_wrt_data  in  XLEN  write-back data
- flush  in  1  clear all pending bits; data is kept
- wb_unexp  out  1  registered pulse: previous-cycle write-back hit a non-pending, non-zero register

## Operation
- Storage: NREGS×XLEN data array plus an NREGS-bit pending vector. Entry 0 reads as 0 and pending[0] is constant 0.
- Reads are asynchronous. rg_rd_dataN = array[addr]. rg_rd_rdyN = !pending[addr].
- Write-back: when rg_wrt_en=1 and rg_wrt_addr≠0, array[rg_wrt_addr] ← rg_wrt_data and pending[rg_wrt_addr] ← 0. A write to address 0 is discarded.
- Issue: when issue_en=1 and issue_addr≠0, pending[issue_addr] ← 1. Issue to address 0 has no effect.
- Issue while pending (issue_ok=0): the pending bit stays set and is not counted. Stalling is the caller's responsibility.
- Same address in one cycle, write-back and issue: data is written and the pending bit ends at 1 (the issue wins).
- flush=1: all pending bits ← 0, then this cycle's issue (if any) applies. This cycle's write-back still writes data.
- wb_unexp ← rg_wrt_en & (rg_wrt_addr≠0) & !pending[rg_wrt_addr], sampled before the update. It is a diagnostic only and does not block the write.
- Reset (synchronous, reset=1 at a clock edge):
  - All data ← 0, all pending ← 0, wb_unexp ← 0.
  - Issue and write-back in that cycle are ignored.
  - Reset mid-operation drops all in-flight pending state.
- After reset: rg_rd_data* = 0, rg_rd_rdy* = 1, issue_ok = 1, wb_unexp = 0.

## Timing
- Write-to-read latency is 1 cycle: a write-back at edge N is visible on the read ports after edge N. Without bypass, a same-cycle read returns the old data with rdy=0.
- An issue at edge N makes rg_rd_rdy*/issue_ok go low after edge N.
- wb_unexp is valid for exactly one cycle, the cycle after the offending write-back.
- No handshake back-pressure. All inputs are sampled every edge.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When rg_wrt_en=1 and rg_wrt_addr≠0 matches rg_rd_addrN, rg_rd_dataN = rg_wrt_data and rg_rd_rdyN = 1 in the same cycle.
  - issue_ok is likewise forced to 1 when write-back targets issue_addr.
  - Bypass is suppressed while reset=1.
- Not defined: no forwarding. Read ports reflect only clocked state.

## Structure
- Shared package regfile_pkg holds:
  - default XLEN/NREGS constants
  - the reg_addr_t / reg_data_t typedefs
  - the localparam ZERO_REG = 0
- One sub-module, regfile_scoreboard, holds the pending vector, flush/issue/write-back update logic, and wb_unexp. The top holds the data array and the read muxes.

## Test plan
- Reset, then read every address → data 0, rdy 1, issue_ok 1, wb_unexp 0.
- Write 0xDEADBEEF to x5, read x5 next cycle → 0xDEADBEEF. Write 0x1234 to x0 → x0 reads 0, wb_unexp stays 0.
- Issue x7, then read x7 → rdy1=0, issue_ok=0. Write-back x7=0x55 three cycles later → rdy1=1 and data 0x55 the next cycle.
- Issue and write-back x9 in the same cycle → data updated, pending stays 1. Then flush → rdy=1 and data preserved.
- Write-back x3 with no prior issue → wb_unexp=1 for exactly one cycle. Assert reset while x4 is pending → x4 data 0, rdy 1.
- With REGFILE_BYPASS_EN defined, write x6=0xA5A5 while reading x6 in the same cycle → rg_rd_data1=0xA5A5 and rdy1=1 combinationally. Without the macro, the old value is returned.
